// File: rtl/rv_alu_pkg.sv
// Shared definitions for the multi-cycle RV32I/M ALU: op codes, FSM states
// and a constant-function log2 used to size shift and iteration counters.
package rv_alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/rv_alu_muldiv_iter.sv
// Shared XLEN-iteration shift-add multiplier / restoring divider on magnitudes.
// Compiled only when RV_ALU_MULDIV_EN is defined.
`ifdef RV_ALU_MULDIV_EN
module rv_alu_muldiv_iter
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_div,
    input  logic [XLEN-1:0]   mag_a,
    input  logic [XLEN-1:0]   mag_b,
    output logic              done,
    output logic [2*XLEN-1:0] res
);

    localparam int CW = clog2_f(XLEN) + 1;

    logic [CW-1:0]   cnt;
    logic            mode_q;
    logic [XLEN-1:0] hi, lo, opnd;
    logic [XLEN:0]   sum, r_sh, diff;

    // hi/lo hold product {hi,lo} or {remainder, quotient} depending on mode
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        r_sh = {hi, lo[XLEN-1]};
        diff = r_sh - {1'b0, opnd};
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt    <= '0;
            mode_q <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
        end else if (start) begin
            cnt    <= CW'(XLEN);
            mode_q <= mode_div;
            hi     <= '0;
            lo     <= mode_div ? mag_a : mag_b;
            opnd   <= mode_div ? mag_b : mag_a;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (!mode_q) begin
                {hi, lo} <= {sum, lo[XLEN-1:1]};
            end else if (!diff[XLEN]) begin
                hi <= diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
                hi <= r_sh[XLEN-1:0];
                lo <= {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign done = (cnt == CW'(1));
    assign res  = {hi, lo};

endmodule
`endif

// File: rtl/rv_alu_seq.sv
// Multi-cycle RV32I ALU with start/ready handshake, optional iterative shifter
// and optional RV32M multiply/divide (enabled by defining RV_ALU_MULDIV_EN).
//
// state | meaning
// IDLE  | waiting for iStart, operands captured on accept
// EXEC  | single-cycle ops, divide special cases, launch of shift/muldiv
// SHIFT | one bit position per cycle until shift counter expires
// MUL   | shift-add iterations in rv_alu_muldiv_iter
// DIV   | restoring-divide iterations in rv_alu_muldiv_iter
// FIX   | sign correction and half / quotient-remainder selection
// DONE  | oRdy pulse, back to IDLE
module rv_alu_seq
    import rv_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_ITER = 1
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iStart,
    input  logic [4:0]      iOP,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    output logic [XLEN-1:0] oC,
    output logic            oRdy,
    output logic            oBusy
);

    localparam int SHW = clog2_f(XLEN);

    state_e          state;
    logic [4:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, sh_val;
    logic [SHW-1:0]  sh_cnt, shamt;
    logic [XLEN-1:0] simple_res, sh_step;
    logic            is_shift;

    assign shamt    = b_q[SHW-1:0];
    assign is_shift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);

    always_comb begin
        simple_res = '0;
        case (op_q)
            OP_ADD:   simple_res = a_q + b_q;
            OP_SUB:   simple_res = a_q - b_q;
            OP_SLL:   simple_res = a_q << shamt;
            OP_SLT:   simple_res = XLEN'($signed(a_q) < $signed(b_q));
            OP_SLTU:  simple_res = XLEN'(a_q < b_q);
            OP_XOR:   simple_res = a_q ^ b_q;
            OP_SRL:   simple_res = a_q >> shamt;
            OP_SRA:   simple_res = $signed(a_q) >>> shamt;
            OP_OR:    simple_res = a_q | b_q;
            OP_AND:   simple_res = a_q & b_q;
            OP_PASSB: simple_res = b_q;
            default:  simple_res = '0;
        endcase
    end

    always_comb begin
        sh_step = {sh_val[XLEN-1], sh_val[XLEN-1:1]};
        if (op_q == OP_SLL)      sh_step = {sh_val[XLEN-2:0], 1'b0};
        else if (op_q == OP_SRL) sh_step = {1'b0, sh_val[XLEN-1:1]};
    end

`ifdef RV_ALU_MULDIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic              is_md, is_div, a_sgn, b_sgn, neg_res;
    logic              div_zero, div_ovf, md_go, md_start, md_done;
    logic [XLEN-1:0]   mag_a, mag_b, div_spec_res, md_fix, quo, rem;
    logic [2*XLEN-1:0] md_res, prod_s;

    always_comb begin
        is_md    = (op_q[4:3] == 2'b10);
        is_div   = is_md && op_q[2];
        a_sgn    = a_q[XLEN-1] && ((op_q == OP_MUL) || (op_q == OP_MULH) ||
                   (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM));
        b_sgn    = b_q[XLEN-1] && ((op_q == OP_MUL) || (op_q == OP_MULH) ||
                   (op_q == OP_DIV) || (op_q == OP_REM));
        mag_a    = a_sgn ? -a_q : a_q;
        mag_b    = b_sgn ? -b_q : b_q;
        div_zero = (b_q == '0);
        div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MOST_NEG) && (&b_q);
        md_go    = is_md && !(is_div && (div_zero || div_ovf));
        md_start = (state == ST_EXEC) && md_go;
        if (div_zero)
            div_spec_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
        else
            div_spec_res = (op_q == OP_DIV) ? a_q : '0;
    end

    // remainder takes the dividend's sign, everything else the product sign
    always_comb begin
        neg_res = a_sgn ^ b_sgn;
        prod_s  = neg_res ? -md_res : md_res;
        quo     = neg_res ? -md_res[XLEN-1:0] : md_res[XLEN-1:0];
        rem     = a_sgn ? -md_res[2*XLEN-1:XLEN] : md_res[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       md_fix = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: md_fix = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              md_fix = quo;
            default:                      md_fix = rem;
        endcase
    end

    rv_alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk_sys  (iClk),
        .rst      (iRst),
        .start    (md_start),
        .mode_div (is_div),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .done     (md_done),
        .res      (md_res)
    );
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sh_val <= '0;
            sh_cnt <= '0;
            oC     <= '0;
            oRdy   <= 1'b0;
            oBusy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        op_q  <= iOP;
                        a_q   <= iA;
                        b_q   <= iB;
                        oBusy <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (SHIFT_ITER != 0 && is_shift && shamt != '0) begin
                        sh_val <= a_q;
                        sh_cnt <= shamt;
                        state  <= ST_SHIFT;
                    end
`ifdef RV_ALU_MULDIV_EN
                    else if (md_go) begin
                        state <= is_div ? ST_DIV : ST_MUL;
                    end else if (is_div) begin
                        oC    <= div_spec_res;
                        oRdy  <= 1'b1;
                        state <= ST_DONE;
                    end
`endif
                    else begin
                        oC    <= simple_res;
                        oRdy  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    sh_val <= sh_step;
                    sh_cnt <= sh_cnt - SHW'(1);
                    if (sh_cnt == SHW'(1)) begin
                        oC    <= sh_step;
                        oRdy  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
`ifdef RV_ALU_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    if (md_done) state <= ST_FIX;
                end
                ST_FIX: begin
                    oC    <= md_fix;
                    oRdy  <= 1'b1;
                    state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    oRdy  <= 1'b0;
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv_alu_seq.md
# rv_alu_seq

Parametrised multi-cycle ALU for the RV32I processor datapath, the successor to the current fixed-width ALU with its `oRdy` handshake. Executes RV32I integer ops at configurable width `XLEN` behind a start/ready handshake: single-cycle logic ops, an optional iterative shifter, and optional RV32M multiply/divide. The control unit issues one operation at a time and waits for `oRdy` before latching `oC` into aluD.

## Interface

- `XLEN`, 32 — datapath width; power of two, ≥ 8.
- `SHIFT_ITER`, 1 — 1: shifter moves one bit position per cycle; 0: single-cycle barrel shift.

Ports:

- `iClk` in 1 — clock; all state changes on its rising edge.
- `iRst` in 1 — reset; synchronous, active-high.
- `iStart` in 1 — issue request; sampled only while `oBusy`=0.
- `iOP` in 5 — operation code from `rv_alu_pkg`.
- `iA` in XLEN — operand A (rs1 or immediate).
- `iB` in XLEN — operand B (rs2 or PC).
- `oC` out XLEN — result; holds last result until next completion.
- `oRdy` out 1 — one-cycle completion pulse; `oC` valid in the same cycle.
- `oBusy` out 1 — operation in flight; new `iStart` ignored.

## Operation

- Ops: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10; MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- Any other code is illegal: result 0, single-cycle latency.
- Operands and op are captured at start; later changes on `iA`/`iB`/`iOP` have no effect.
- Arithmetic is modulo 2^XLEN. SLT/SLTU produce zero-extended 0/1.
- Shift amount is `iB[log2(XLEN)-1:0]`. SRA replicates the sign bit.
- States:
  - IDLE: start → EXEC.
  - EXEC: one cycle for simple ops and special cases → DONE.
  - SHIFT: one bit position per cycle, counter counts down shamt → DONE.
  - MUL: shift-add over magnitudes, XLEN iterations → FIX.
  - DIV: restoring divide over magnitudes, XLEN iterations → FIX.
  - FIX: sign correction and selection of high or low half / quotient or remainder → DONE.
  - DONE: `oRdy`=1 → IDLE.
- Divide special cases complete from EXEC and never enter DIV:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = dividend.
  - Signed overflow (DIV/REM with most-negative ÷ −1): DIV = dividend, REM = 0.
- `oBusy`=1 in every state except IDLE.

## Timing

- Reset: `oC`=0, `oRdy`=0, `oBusy`=0, state IDLE, counters 0. A reset during an operation aborts it with no `oRdy` pulse.
- Cycle numbering: `iStart` accepted at edge 0; `oRdy` is reported at edge N.
- Simple ops, illegal ops, divide special cases, and shifts with `SHIFT_ITER`=0: N=2.
- Iterative shift: N = 2 + shamt, so shamt 0 gives N=2 and shamt XLEN-1 gives N=XLEN+1.
- MUL*/DIV*/REM*: N = XLEN + 3, fixed regardless of operand values.
- `iStart` held high across DONE→IDLE starts the next op on the first IDLE cycle (back-to-back, one idle cycle between ops).
- `oRdy` and `oBusy` are never simultaneously 0 during an accepted operation.

## Configuration

- `RV_ALU_MULDIV_EN` defined: opcodes 16–23 execute as above.
- Not defined: opcodes 16–23 are illegal (result 0, N=2), and the MUL/DIV/FIX states and iteration datapath are not compiled.

## Structure

- `rv_alu_pkg` holds:
  - op-code localparams or enum;
  - state enum;
  - helper `clog2` width constant for shamt and iteration counters.
- Sub-module `rv_alu_muldiv_iter`, present only under the macro:
  - shared XLEN-iteration shift-add / restoring-divide datapath;
  - ports: operand magnitudes, mode, start, done, 2·XLEN product or quotient/remainder.
- Top holds the FSM, simple-op logic, shifter and sign fix-up.

## Test plan

- Reset mid-DIV (at cycle 10) → next cycle `oBusy`=0, `oC`=0, no `oRdy` pulse; next ADD completes normally.
- ADD 0xFFFFFFFF + 1 → `oC`=0, `oRdy` at N=2. SLT −1,1 → 1. SLTU −1,1 → 0. iOP=12 → 0.
- SRA 0x80000000 by 31 with `SHIFT_ITER`=1 → `oC`=0xFFFFFFFF, `oRdy` at N=33. By 0 → unchanged value, N=2.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF; MUL 7×−3 → 0xFFFFFFEB, all N=35.
- DIV −7÷2 → 0xFFFFFFFD and REM → 0xFFFFFFFF, N=35. DIVU x÷0 → 0xFFFFFFFF, N=2. DIV 0x80000000÷−1 → 0x80000000, N=2.
- `iStart` pulsed while busy → ignored. Macro undefined → MUL returns 0 at N=2. XLEN=16 ADD 0xFFFF+1 → 0.
